// File: rtl/fib_sched.sv
`default_nettype none
// ============================================================================
// Module   : fib_sched
// Brief    : Round-robin scheduler sharing one Fibonacci generator between
//            NREQ requesters, with a two-entry valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module fib_sched #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int LENW      = 5,
    parameter int MAX_TERMS = 24,
    parameter int DW        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] req_len,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 err,
    output logic                 gen_rst,
    output logic                 gen_en,
    input  logic                 gen_valid,
    input  logic [DW-1:0]        gen_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [IDW-1:0]       out_id,
    output logic                 out_last
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESTART = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    localparam logic [LENW-1:0] c_max_len  = LENW'(MAX_TERMS);
    localparam logic [NREQ-1:0] c_gnt_one  = NREQ'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_id;
    logic [LENW-1:0]   r_len;
    logic [LENW-1:0]   r_issued;
    logic [LENW-1:0]   r_recv;
    logic [NREQ-1:0]   r_gnt;
    logic              r_err;
    logic              r_gen_rst;
    logic              r_out_valid;
    logic              r_out_last;
    logic [DW-1:0]     r_out_data;
    logic              r_skid_valid;
    logic              r_skid_last;
    logic [DW-1:0]     r_skid_data;

    logic              w_sel_found;
    logic [IDW-1:0]    w_sel_id;
    logic [IDW-1:0]    w_scan_idx;
    logic [LENW-1:0]   w_sel_len;
    logic              w_sel_legal;
    logic              w_drain;
    logic              w_done;
    logic              w_abort;
    logic              w_push;
    logic              w_push_last;
    logic [1:0]        w_occ;

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        w_scan_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_sel_found && req[w_scan_idx]) begin
                w_sel_found = 1'b1;
                w_sel_id    = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_sel_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel_id == IDW'(i)) begin
                w_sel_len = req_len[i*LENW +: LENW];
            end
        end
    end

    assign w_sel_legal = (w_sel_len != '0) && (w_sel_len <= c_max_len);
    assign w_drain     = r_out_valid & out_ready;
    assign w_done      = (r_state == S_RUN) && w_drain && r_out_last;
    assign w_abort     = (r_state != S_IDLE) && !req[r_id];
    assign w_push      = (r_state == S_RUN) && gen_valid && (r_issued != r_recv);
    assign w_push_last = ((r_recv + 1'b1) == r_len);

    // Terms in flight plus buffered, less the one leaving this cycle.
    assign w_occ = 2'(r_issued != r_recv) + 2'(r_out_valid) + 2'(r_skid_valid)
                 - 2'(w_drain);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        gen_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found && w_sel_legal) begin
                    w_next_state = S_RESTART;
                end
            end
            S_RESTART: begin
                w_next_state = w_abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                gen_en = !r_gen_rst && (r_issued < r_len) && (w_occ < 2'd2);
                if (w_abort || w_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr        <= IDW'(NREQ - 1);
            r_id         <= '0;
            r_len        <= '0;
            r_gnt        <= '0;
            r_err        <= 1'b0;
            r_gen_rst    <= 1'b0;
            r_issued     <= '0;
            r_recv       <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_err     <= 1'b0;
            r_gen_rst <= (r_state == S_RESTART) && !w_abort;

            if (r_state == S_IDLE && w_sel_found) begin
                r_ptr <= w_sel_id;
                r_id  <= w_sel_id;
                r_len <= w_sel_len;
                if (w_sel_legal) begin
                    r_gnt <= c_gnt_one << w_sel_id;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (w_abort || w_done) begin
                r_gnt <= '0;
            end

            if (r_state != S_RUN || w_abort || w_done) begin
                r_issued     <= '0;
                r_recv       <= '0;
                r_out_valid  <= 1'b0;
                r_out_last   <= 1'b0;
                r_skid_valid <= 1'b0;
                r_skid_last  <= 1'b0;
            end else begin
                if (gen_en) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (w_push) begin
                    r_recv <= r_recv + 1'b1;
                end
                // The skid entry always moves forward first to keep term order.
                if (!r_out_valid || w_drain) begin
                    if (r_skid_valid) begin
                        r_out_valid  <= 1'b1;
                        r_out_data   <= r_skid_data;
                        r_out_last   <= r_skid_last;
                        r_skid_valid <= w_push;
                        if (w_push) begin
                            r_skid_data <= gen_data;
                            r_skid_last <= w_push_last;
                        end
                    end else if (w_push) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= gen_data;
                        r_out_last  <= w_push_last;
                    end else begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end else if (w_push) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= gen_data;
                    r_skid_last  <= w_push_last;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;
    assign gen_rst   = r_gen_rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_id;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_fib_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_sched
// Brief    : Scoreboard bench for fib_sched with a behavioural generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_sched;

    localparam int NREQ      = 4;
    localparam int IDW       = 2;
    localparam int LENW      = 5;
    localparam int MAX_TERMS = 24;
    localparam int DW        = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*LENW-1:0] req_len;
    logic [LENW-1:0]      lens [NREQ];
    logic [NREQ-1:0]      gnt;
    logic                 busy, err, gen_rst, gen_en;
    logic                 gen_valid = 1'b0;
    logic [DW-1:0]        gen_data  = '0;
    logic                 out_valid, out_ready, out_last;
    logic [DW-1:0]        out_data;
    logic [IDW-1:0]       out_id;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) req_len[i*LENW +: LENW] = lens[i];
    end

    fib_sched #(.NREQ(NREQ), .IDW(IDW), .LENW(LENW), .MAX_TERMS(MAX_TERMS), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .gnt(gnt), .busy(busy),
        .err(err), .gen_rst(gen_rst), .gen_en(gen_en), .gen_valid(gen_valid),
        .gen_data(gen_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .out_last(out_last)
    );

    // Generator: restart yields 1,1,2,3,...; each gen_en answers one cycle later.
    logic [DW-1:0] g_a = 16'd1, g_b = 16'd1;
    always @(posedge clk) begin
        gen_valid <= 1'b0;
        if (gen_rst) begin
            g_a <= 16'd1;
            g_b <= 16'd1;
        end else if (gen_en) begin
            gen_valid <= 1'b1;
            gen_data  <= g_a;
            g_a       <= g_b;
            g_b       <= g_a + g_b;
        end
    end

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           last;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, gr_cnt = 0, gr_cyc = 0, gnt_cyc = 0, en_first_cyc = -1;
    int en_total = 0, err_total = 0, acc_cnt = 0, done_cnt = 0, done_id = 0;
    int hs_first = -1, hs_last = 0, occ_en = 0, occ_acc = 0;
    bit track = 0, stalled = 0;
    logic [NREQ-1:0] prev_gnt = '0;
    logic [DW-1:0] h_data;
    logic [IDW-1:0] h_id;
    logic h_last;
    int rmode = 0, pidx = 0, m_ptr = NREQ - 1;
    bit rearm;
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    function automatic int fib(int k);
        int a = 1, b = 1, t;
        for (int i = 1; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int rr_pick(int ptr, logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_burst(input int id, input int len, input int count);
        exp_t e;
        for (int k = 1; k <= count; k++) begin
            e.id   = IDW'(id);
            e.data = DW'(fib(k));
            e.last = (k == len);
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (gen_rst) begin
                gr_cnt++; gr_cyc = cyc; occ_en = 0; occ_acc = 0;
                track = 1; hs_first = -1; en_first_cyc = -1;
            end
            if (gnt == '0) track = 0;
            if (gnt != '0 && prev_gnt == '0) gnt_cyc = cyc;
            prev_gnt = gnt;
            if (err) err_total++;
            if (gen_en) begin
                en_total++;
                if (en_first_cyc < 0) en_first_cyc = cyc;
            end
            if (track && !gen_rst) begin
                checks++;
                if (occ_en - occ_acc > 2) begin
                    errors++;
                    $display("FAIL occupancy: got %0d outstanding, expected at most 2", occ_en - occ_acc);
                end
            end
            if (stalled && gnt != '0) begin
                checks++;
                if (!out_valid || out_data !== h_data || out_id !== h_id || out_last !== h_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%0d id=%0d l=%0b, expected v=1 d=%0d id=%0d l=%0b",
                             out_valid, out_data, out_id, out_last, h_data, h_id, h_last);
                end
            end
            if (out_valid) chk("gnt_vs_id", gnt, 1 << out_id);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_term: got d=%0d id=%0d, expected no term", out_data, out_id);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_id !== e.id || out_last !== e.last) begin
                        errors++;
                        $display("FAIL term: got d=%0d id=%0d l=%0b, expected d=%0d id=%0d l=%0b",
                                 out_data, out_id, out_last, e.data, e.id, e.last);
                    end
                end
                acc_cnt++;
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
                if (out_last) begin
                    done_cnt++;
                    done_id = int'(out_id);
                end
            end
            occ_en  += int'(gen_en);
            occ_acc += int'(out_valid && out_ready);
            stalled = out_valid && !out_ready;
            h_data = out_data; h_id = out_id; h_last = out_last;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: begin out_ready = pat[pidx % 7] != 0; pidx++; end
            2: out_ready = $urandom_range(0, 1) != 0;
            default: out_ready = 1'b0;
        endcase
    endtask

    // Drops each requester after its last term is accepted, except one re-arm.
    task automatic run_until_idle(input int budget, input int rearm_id);
        int seen = done_cnt;
        int n = 0;
        rearm = (rearm_id >= 0);
        while (req != '0 && n < budget) begin
            tick();
            n++;
            if (done_cnt != seen) begin
                seen = done_cnt;
                chk("gnt_after_last", gnt, 0);
                chk("busy_after_last", busy, 0);
                if (rearm && done_id == rearm_id) rearm = 0;
                else req[done_id] = 1'b0;
            end
        end
        if (req != '0) begin
            errors++; checks++;
            $display("FAIL burst_timeout: got req=%b still pending, expected 0", req);
            req = '0;
        end
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("accept_reached", acc_cnt >= target, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, gnt, 0);       chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);       chk({tag, "_gen_rst"}, gen_rst, 0);
        chk({tag, "_gen_en"}, gen_en, 0); chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_id"}, out_id, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_en, snap_gr, snap_err, id, a0;
        logic [NREQ-1:0] mask, rem;
        fork monitor(); join_none
        rst = 1'b0; req = '0; out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) lens[i] = '0;
        #12;
        check_reset_outputs("reset");
        tick(); rst = 1'b1;
        tick();

        // Single request
        lens[0] = 5; push_burst(0, 5, 5); m_ptr = 0;
        snap_gr = gr_cnt;
        req[0] = 1'b1;
        tick();
        chk("single_gnt", gnt, 1);
        run_until_idle(200, -1);
        chk("single_gen_rst_pulses", gr_cnt - snap_gr, 1);
        chk("gen_rst_after_gnt", gr_cyc, gnt_cyc + 1);
        chk("gen_en_after_gen_rst", en_first_cyc, gr_cyc + 1);
        chk("single_throughput", hs_last - hs_first, 4);

        // Round-robin from reset with req0 re-raised after its burst
        tick(); rst = 1'b0; tick(); rst = 1'b1; m_ptr = NREQ - 1;
        lens[0] = 3; lens[2] = 3;
        id = rr_pick(m_ptr, 4'b0101); push_burst(id, 3, 3); m_ptr = id;
        id = rr_pick(m_ptr, 4'b0101); push_burst(id, 3, 3); m_ptr = id;
        id = rr_pick(m_ptr, 4'b0101 & ~(4'b0001 << id)); push_burst(id, 3, 3); m_ptr = id;
        snap_gr = gr_cnt;
        req = 4'b0101;
        run_until_idle(400, 0);
        chk("rr_gen_rst_pulses", gr_cnt - snap_gr, 3);

        // Backpressure
        rmode = 1; pidx = 0;
        lens[1] = 6; push_burst(1, 6, 6); m_ptr = 1;
        req[1] = 1'b1;
        run_until_idle(400, -1);
        rmode = 0;

        // Illegal lengths
        snap_en = en_total; snap_gr = gr_cnt; snap_err = err_total;
        lens[3] = 0; req[3] = 1'b1; tick();
        chk("len0_err", err, 1); chk("len0_gnt", gnt, 0);
        req[3] = 1'b0; tick();
        chk("len0_err_pulse", err, 0); chk("len0_busy", busy, 0);
        lens[1] = 25; req[1] = 1'b1; tick();
        chk("len25_err", err, 1); chk("len25_gnt", gnt, 0);
        req[1] = 1'b0; tick(); tick();
        chk("len25_err_pulse", err, 0);
        chk("illegal_err_count", err_total - snap_err, 2);
        chk("illegal_no_gen_en", en_total - snap_en, 0);
        chk("illegal_no_gen_rst", gr_cnt - snap_gr, 0);
        m_ptr = 1;

        // Max burst
        snap_err = err_total;
        lens[2] = 24; push_burst(2, 24, 24); m_ptr = 2;
        req[2] = 1'b1;
        run_until_idle(400, -1);
        chk("max_throughput", hs_last - hs_first, 23);
        chk("max_no_err", err_total - snap_err, 0);

        // Abort after two accepted terms
        lens[1] = 10; push_burst(1, 10, 2); m_ptr = 1;
        a0 = acc_cnt;
        req[1] = 1'b1;
        wait_acc(a0 + 2, 200);
        req[1] = 1'b0; rmode = 3; out_ready = 1'b0;
        tick();
        chk("abort_gnt", gnt, 0); chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        rmode = 0;
        tick(); tick();
        chk("abort_queue", exp_q.size(), 0);
        lens[0] = 3; push_burst(0, 3, 3); m_ptr = 0;
        req[0] = 1'b1;
        run_until_idle(200, -1);

        // Randomized simultaneous bursts with random backpressure
        rmode = 2;
        for (int r = 0; r < 4; r++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) lens[i] = LENW'($urandom_range(1, MAX_TERMS));
            rem = mask;
            while (rem != '0) begin
                id = rr_pick(m_ptr, rem);
                push_burst(id, int'(lens[id]), int'(lens[id]));
                m_ptr = id;
                rem[id] = 1'b0;
            end
            req = mask;
            run_until_idle(3000, -1);
        end
        rmode = 0;

        // Asynchronous reset in the middle of a burst
        lens[3] = 10; push_burst(3, 10, 10);
        a0 = acc_cnt;
        req[3] = 1'b1;
        wait_acc(a0 + 3, 200);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async");
        exp_q.delete();
        req = '0;
        tick(); rst = 1'b1; m_ptr = NREQ - 1;
        lens[2] = 2; push_burst(2, 2, 2); m_ptr = 2;
        req[2] = 1'b1;
        run_until_idle(200, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
